// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX/DM hazard inputs plus stall/flush enables
// and performance-counter outputs. master = pipeline side, slave = controller.
interface hazard_ctrl_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  logic [AW-1:0]    rs1_addr_id;
  logic [AW-1:0]    rs2_addr_id;
  logic             rs1_used_id;
  logic             rs2_used_id;
  logic             dmem_wr_id;
  logic             dmem_rd_ex;
  logic             regfile_wen_ex;
  logic [AW-1:0]    rd_addr_ex;
  logic             branch_taken_ex;
  logic             md_start_ex;
  logic             md_done;
  logic             dmem_req_dm;
  logic             dmem_ready;
  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_stall;
  logic             idex_flush;
  logic             exdm_stall;
  logic             exdm_flush;
  logic             dmwb_flush;
  logic             md_timeout;
  logic [CNT_W-1:0] lu_stall_cnt;
  logic [CNT_W-1:0] md_stall_cnt;
  logic [CNT_W-1:0] mem_stall_cnt;

  modport master (
    output rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id, dmem_wr_id,
           dmem_rd_ex, regfile_wen_ex, rd_addr_ex, branch_taken_ex,
           md_start_ex, md_done, dmem_req_dm, dmem_ready,
    input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exdm_stall, exdm_flush, dmwb_flush, md_timeout,
           lu_stall_cnt, md_stall_cnt, mem_stall_cnt
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id, dmem_wr_id,
           dmem_rd_ex, regfile_wen_ex, rd_addr_ex, branch_taken_ex,
           md_start_ex, md_done, dmem_req_dm, dmem_ready,
    output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exdm_stall, exdm_flush, dmwb_flush, md_timeout,
           lu_stall_cnt, md_stall_cnt, mem_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage core.
// Covers load-use bubbles, taken-branch redirect, mul/div freeze and DMEM wait.
// Optional macro HAZARD_PERF_CNT_EN builds saturating stall-cycle counters;
// without it the counter outputs are tied to zero.
module hazard_ctrl #(
  parameter int AW            = 5,
  parameter int MD_MAX_CYCLES = 64,
  parameter int CNT_W         = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, MD_BUSY, MEM_WAIT} state_t;

  localparam int           BW    = $clog2(MD_MAX_CYCLES + 1);
  localparam logic [BW-1:0] BMAX  = BW'(MD_MAX_CYCLES);
  localparam logic [BW-1:0] BLAST = BW'(MD_MAX_CYCLES - 1);

  state_t        state, state_nxt;
  logic          md_pend, md_pend_nxt;  // mul/div still outstanding across a DMEM wait
  logic [BW-1:0] busy_cnt;
  logic          md_timeout;

  logic lu, mem_hold;
  logic lu_cyc, md_cyc, mem_cyc;        // which condition owns pc_stall this cycle
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic exdm_stall, exdm_flush, dmwb_flush;

  // Load-use: EX load targets a register ID reads. Store data (rs2 of a store)
  // is forwarded into DMEM din, so it never needs a bubble.
  assign lu = hz.dmem_rd_ex & hz.regfile_wen_ex & (hz.rd_addr_ex != '0) &
              ((hz.rs1_used_id & (hz.rs1_addr_id == hz.rd_addr_ex)) |
               (hz.rs2_used_id & ~hz.dmem_wr_id & (hz.rs2_addr_id == hz.rd_addr_ex)));

  assign mem_hold = hz.dmem_req_dm & ~hz.dmem_ready;

  // Next state and stall/flush decode; priority MEM > MD > branch > load-use
  always_comb begin
    state_nxt   = state;
    md_pend_nxt = md_pend;
    lu_cyc      = 1'b0;
    md_cyc      = 1'b0;
    mem_cyc     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mem_hold) begin
            mem_cyc     = 1'b1;
            md_pend_nxt = 1'b0;
            state_nxt   = MEM_WAIT;
          end else if (hz.md_start_ex && !hz.md_done) begin
            md_cyc    = 1'b1;
            state_nxt = MD_BUSY;
          end else if (hz.branch_taken_ex) begin
            // wrong-path ID instruction is squashed, so any load-use is moot
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (lu) begin
            lu_cyc     = 1'b1;
            idex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (mem_hold) begin
            mem_cyc     = 1'b1;
            md_pend_nxt = ~hz.md_done;
            state_nxt   = MEM_WAIT;
          end else if (hz.md_done) begin
            state_nxt = RUN;
          end else begin
            md_cyc = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (hz.md_done) md_pend_nxt = 1'b0;
          if (!hz.dmem_ready) begin
            mem_cyc = 1'b1;
          end else begin
            state_nxt = (md_pend && !hz.md_done) ? MD_BUSY : RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
    pc_stall   = lu_cyc | md_cyc | mem_cyc;
    ifid_stall = lu_cyc | md_cyc | mem_cyc;
    idex_stall = md_cyc | mem_cyc;
    idex_flush = idex_flush | lu_cyc;
    exdm_stall = mem_cyc;
    exdm_flush = md_cyc;
    dmwb_flush = mem_cyc;
  end

  // FSM state and pending mul/div flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      md_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_pend <= md_pend_nxt;
    end
  end

  // Mul/div busy watchdog: counts MD_BUSY cycles, clears in RUN, holds in MEM_WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt   <= '0;
      md_timeout <= 1'b0;
    end else if (state == RUN) begin
      busy_cnt <= '0;
    end else if (state == MD_BUSY) begin
      if (busy_cnt != BMAX) busy_cnt <= busy_cnt + 1'b1;
      if (busy_cnt >= BLAST) md_timeout <= 1'b1;
    end
  end

  assign hz.pc_stall   = pc_stall;
  assign hz.ifid_stall = ifid_stall;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_stall = idex_stall;
  assign hz.idex_flush = idex_flush;
  assign hz.exdm_stall = exdm_stall;
  assign hz.exdm_flush = exdm_flush;
  assign hz.dmwb_flush = dmwb_flush;
  assign hz.md_timeout = md_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt, md_cnt, mem_cnt;

  // Saturating stall-cycle counters, one owner per stalled cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt  <= '0;
      md_cnt  <= '0;
      mem_cnt <= '0;
    end else begin
      if (lu_cyc  && lu_cnt  != '1) lu_cnt  <= lu_cnt  + 1'b1;
      if (md_cyc  && md_cnt  != '1) md_cnt  <= md_cnt  + 1'b1;
      if (mem_cyc && mem_cnt != '1) mem_cnt <= mem_cnt + 1'b1;
    end
  end

  assign hz.lu_stall_cnt  = lu_cnt;
  assign hz.md_stall_cnt  = md_cnt;
  assign hz.mem_stall_cnt = mem_cnt;
`else
  logic unused_cnt_src;
  assign unused_cnt_src   = ^{lu_cyc, md_cyc, mem_cyc};
  assign hz.lu_stall_cnt  = '0;
  assign hz.md_stall_cnt  = '0;
  assign hz.mem_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed spec scenarios then randomized
// traffic, each cycle's expectation produced by a pipeline-level model.
module tb_hazard_ctrl;
  localparam int AW    = 5;
  localparam int MDMAX = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // expected output vectors {pc,ifid_st,ifid_fl,idex_st,idex_fl,exdm_st,exdm_fl,dmwb_fl}
  localparam logic [7:0] P_MEM = 8'b11010101;
  localparam logic [7:0] P_MD  = 8'b11010010;
  localparam logic [7:0] P_BR  = 8'b00101000;
  localparam logic [7:0] P_LU  = 8'b11001000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.AW(AW), .CNT_W(CNT_W)) hz();
  hazard_ctrl #(.AW(AW), .MD_MAX_CYCLES(MDMAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hz(hz));

  typedef struct {
    bit rst;
    logic [AW-1:0] rs1, rs2, rd;
    bit u1, u2, wr, ld, wen, br, mds, mdd, req, rdy;
  } stim_t;

  typedef struct {
    logic [7:0] o;
    bit tmo;
    int lu, md, mem;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // pipeline-level model: is a mul/div outstanding, is DM waiting on memory
  bit m_md_out, m_mem_wait, m_tmo;
  int m_busy, m_lu, m_md, m_mem;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic model(input stim_t s, output exp_t e);
    bit hit, mz, mdz;
    e.tmo = m_tmo; e.lu = m_lu; e.md = m_md; e.mem = m_mem;
    e.o = '0;
    mz = 0; mdz = 0;
    if (s.rst) begin
      m_md_out = 0; m_mem_wait = 0; m_busy = 0; m_tmo = 0;
      m_lu = 0; m_md = 0; m_mem = 0;
      return;
    end
    hit = s.ld && s.wen && s.rd != 0 &&
          ((s.u1 && s.rs1 == s.rd) || (s.u2 && !s.wr && s.rs2 == s.rd));
    // watchdog sees the phase at the start of the cycle
    if (!m_mem_wait && m_md_out) begin
      m_busy++;
      if (m_busy >= MDMAX) m_tmo = 1;
    end else if (!m_mem_wait) begin
      m_busy = 0;
    end
    if (m_mem_wait) begin
      if (s.mdd) m_md_out = 0;
      if (!s.rdy) mz = 1; else m_mem_wait = 0;
    end else if (s.req && !s.rdy) begin
      mz = 1; m_mem_wait = 1;
      if (s.mdd) m_md_out = 0;
    end else if (m_md_out) begin
      if (s.mdd) m_md_out = 0; else mdz = 1;
    end else if (s.mds && !s.mdd) begin
      mdz = 1; m_md_out = 1;
    end else if (s.br) begin
      e.o = P_BR;
    end else if (hit) begin
      e.o = P_LU;
`ifdef HAZARD_PERF_CNT_EN
      if (m_lu < CMAX) m_lu++;
`endif
    end
    if (mz) e.o = P_MEM;
    if (mdz) e.o = P_MD;
`ifdef HAZARD_PERF_CNT_EN
    if (mz && m_mem < CMAX) m_mem++;
    if (mdz && m_md < CMAX) m_md++;
`endif
  endtask

  task automatic drive(input stim_t s);
    rst = s.rst;
    hz.rs1_addr_id = s.rs1;  hz.rs2_addr_id = s.rs2;
    hz.rs1_used_id = s.u1;   hz.rs2_used_id = s.u2;
    hz.dmem_wr_id  = s.wr;   hz.dmem_rd_ex  = s.ld;
    hz.regfile_wen_ex = s.wen; hz.rd_addr_ex = s.rd;
    hz.branch_taken_ex = s.br; hz.md_start_ex = s.mds;
    hz.md_done = s.mdd;      hz.dmem_req_dm = s.req;
    hz.dmem_ready = s.rdy;
  endtask

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    drive(s);
    model(s, e);
    q.push_back(e);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(idle());
  endtask

  // monitor: every cycle is an output; compare away from the active edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [7:0] a;
      e = q.pop_front();
      a = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_stall,
           hz.idex_flush, hz.exdm_stall, hz.exdm_flush, hz.dmwb_flush};
      total++;
      if (a !== e.o) begin
        bad++;
        $display("FAIL stall_flush t=%0t got=%b want=%b", $time, a, e.o);
      end
      total++;
      if (hz.md_timeout !== e.tmo) begin
        bad++;
        $display("FAIL md_timeout t=%0t got=%b want=%b", $time, hz.md_timeout, e.tmo);
      end
      total++;
      if (hz.lu_stall_cnt !== CNT_W'(e.lu) || hz.md_stall_cnt !== CNT_W'(e.md) ||
          hz.mem_stall_cnt !== CNT_W'(e.mem)) begin
        bad++;
        $display("FAIL counters t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
                 hz.lu_stall_cnt, hz.md_stall_cnt, hz.mem_stall_cnt, e.lu, e.md, e.mem);
      end
    end
  end

  initial begin
    stim_t s;
    int pd;
    s = idle();
    s.rst = 1;
    drive(s);
    repeat (2) @(posedge clk);

    // reset state
    step(s); step(s);

    // ld x5 / add x6,x5,x1 -> one bubble
    s = idle(); s.ld = 1; s.wen = 1; s.rd = 5; s.u1 = 1; s.rs1 = 5; s.u2 = 1; s.rs2 = 1;
    step(s); idle_n(1);
    // ld x5 / sw x5 (store data only) -> no stall
    s = idle(); s.ld = 1; s.wen = 1; s.rd = 5; s.u1 = 1; s.rs1 = 1; s.u2 = 1; s.rs2 = 5; s.wr = 1;
    step(s);
    // load into x0 -> no stall
    s = idle(); s.ld = 1; s.wen = 1; s.rd = 0; s.u1 = 1; s.rs1 = 0;
    step(s);
    // branch overrides load-use
    s = idle(); s.ld = 1; s.wen = 1; s.rd = 7; s.u1 = 1; s.rs1 = 7; s.br = 1;
    step(s);

    // mul/div: done 8 cycles after start
    s = idle(); s.mds = 1; step(s);
    idle_n(7);
    s = idle(); s.mdd = 1; step(s);
    // 1-cycle op: start and done together
    s = idle(); s.mds = 1; s.mdd = 1; step(s);

    // DMEM wait of 3 cycles inside MD_BUSY, then back to MD_BUSY
    s = idle(); s.mds = 1; step(s);
    idle_n(2);
    s = idle(); s.req = 1; s.rdy = 0;
    repeat (3) step(s);
    s.rdy = 1; step(s);
    idle_n(2);
    s = idle(); s.mdd = 1; step(s);

    // watchdog: done withheld past the limit, sticky, cleared by reset
    s = idle(); s.mds = 1; step(s);
    idle_n(MDMAX + 6);
    s = idle(); s.mdd = 1; step(s);
    idle_n(3);
    s = idle(); s.rst = 1; s.mds = 1; s.req = 1; s.rdy = 0; step(s);
    idle_n(2);

    // randomized traffic in phases with different mul/div completion rates
    for (int ph = 0; ph < 6; ph++) begin
      pd = (ph % 3 == 0) ? 1 : ((ph % 3 == 1) ? 10 : 40);
      for (int i = 0; i < 500; i++) begin
        s.rst = ($urandom_range(0, 249) == 0);
        s.rs1 = AW'($urandom_range(0, 3));
        s.rs2 = AW'($urandom_range(0, 3));
        s.rd  = AW'($urandom_range(0, 3));
        s.u1  = $urandom_range(0, 99) < 70;
        s.u2  = $urandom_range(0, 99) < 60;
        s.wr  = $urandom_range(0, 99) < 30;
        s.ld  = $urandom_range(0, 99) < 40;
        s.wen = $urandom_range(0, 99) < 80;
        s.br  = $urandom_range(0, 99) < 15;
        s.mds = $urandom_range(0, 99) < 10;
        s.mdd = $urandom_range(0, 99) < pd;
        s.req = $urandom_range(0, 99) < 30;
        s.rdy = $urandom_range(0, 99) < 50;
        step(s);
      end
    end

    idle_n(1);
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
